// File: rtl/stage_memory_lsu_pkg.sv
// Shared core definitions for the memory stage: FSM states, funct3 access codes
// and the access-size decode shared by the LSU and its load aligner.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } mem_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // log2 of the access size in bytes; unknown or unsupported codes mean full width
    function automatic logic [1:0] access_size(input logic [2:0] f3, input int xlen);
        case (f3)
            F3_B, F3_BU: access_size = 2'd0;
            F3_H, F3_HU: access_size = 2'd1;
            F3_W, F3_WU: access_size = 2'd2;
            default:     access_size = (xlen == 64) ? 2'd3 : 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/stage_memory_lsu_if.sv
// Data-memory req/gnt/rvalid bus between the memory stage (master) and memory (slave).
interface stage_memory_lsu_if #(
    parameter int XLEN = 32
) ();
    logic              dmem_req;
    logic              dmem_we;
    logic [XLEN-1:0]   dmem_addr;
    logic [XLEN/8-1:0] dmem_be;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [XLEN-1:0]   dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/stage_memory_lsu_load_align.sv
// Load aligner: shifts the addressed bytes down to bit 0 and sign/zero-extends them.
module load_align
    import core_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              rdata,
    input  logic [$clog2(XLEN/8)-1:0]    offset,
    input  logic [2:0]                   funct3,
    output logic [XLEN-1:0]              result
);
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] low_mask;
    logic            sign_bit;
    int              nbits;

    always_comb begin
        shifted  = rdata >> {offset, 3'b000};
        nbits    = 8 << access_size(funct3, XLEN);
        low_mask = ~({XLEN{1'b1}} << nbits);
        // MSB of the accessed field; a full-width access has nothing to extend into
        sign_bit = ~funct3[2] & (|(shifted & low_mask & ~(low_mask >> 1)));
        result   = (shifted & low_mask) | (sign_bit ? ~low_mask : '0);
    end
endmodule

// File: rtl/stage_memory_lsu.sv
// Memory pipeline stage / load-store unit between execute and writeback.
// Optional feature macro MEM_MISALIGN_TRAP_EN: trap misaligned accesses instead of aligning them.
module stage_memory_lsu
    import core_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [XLEN-1:0]       ex_store_data,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    input  logic [2:0]            ex_funct3,
    input  logic                  ex_wr_enable,
    input  logic                  flush,
    output logic                  mem_stall,
    stage_memory_lsu_if.master    dmem,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [XLEN-1:0]       wb_result,
    output logic                  wb_wr_enable,
    output logic                  misalign
);
    localparam int BE_W  = XLEN / 8;
    localparam int OFF_W = $clog2(BE_W);

    mem_state_t            state, state_next;
    logic                  ld_load, ld_wr, killed;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [2:0]            ld_f3;
    logic [OFF_W-1:0]      ld_off;
    logic [1:0]            sz;
    logic [XLEN-1:0]       align_mask, addr_aligned, wdata_rep, load_result;
    logic [BE_W-1:0]       be_calc;
    logic                  is_mem, trap;
    logic                  accept_mem, accept_alu, take_trap, drop_req, retire;

    always_comb begin
        sz           = access_size(ex_funct3, XLEN);
        align_mask   = XLEN'((1 << sz) - 1);
        addr_aligned = ex_alu_result & ~align_mask;
        be_calc      = BE_W'(((1 << (1 << sz)) - 1) << addr_aligned[OFF_W-1:0]);
        case (sz)
            2'd0:    wdata_rep = {BE_W{ex_store_data[7:0]}};
            2'd1:    wdata_rep = {(BE_W/2){ex_store_data[15:0]}};
            2'd2:    wdata_rep = {(XLEN/32){ex_store_data[31:0]}};
            default: wdata_rep = ex_store_data;
        endcase
    end

    assign is_mem = ex_mem_read | ex_mem_write;
`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = is_mem & (|(ex_alu_result & align_mask));
`else
    assign trap = 1'b0;
`endif

    assign mem_stall = (state != IDLE);

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem.dmem_rdata),
        .offset (ld_off),
        .funct3 (ld_f3),
        .result (load_result)
    );

    always_comb begin
        state_next = state;
        accept_mem = 1'b0;
        accept_alu = 1'b0;
        take_trap  = 1'b0;
        drop_req   = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (ex_valid && !flush) begin
                    if (!is_mem) begin
                        accept_alu = 1'b1;
                    end else if (trap) begin
                        take_trap = 1'b1;
                    end else begin
                        accept_mem = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem.dmem_gnt) begin
                    drop_req = 1'b1;
                    if (ld_load) begin
                        state_next = WAIT;
                    end else begin
                        state_next = IDLE;
                        retire     = !flush;
                    end
                end else if (flush) begin
                    drop_req   = 1'b1;
                    state_next = IDLE;
                end
            end
            WAIT: begin
                if (dmem.dmem_rvalid) begin
                    state_next = IDLE;
                    retire     = !(killed || flush);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_be    <= '0;
            dmem.dmem_wdata <= '0;
            wb_valid        <= 1'b0;
            wb_rd           <= '0;
            wb_result       <= '0;
            wb_wr_enable    <= 1'b0;
            misalign        <= 1'b0;
            ld_load         <= 1'b0;
            ld_wr           <= 1'b0;
            ld_rd           <= '0;
            ld_f3           <= '0;
            ld_off          <= '0;
            killed          <= 1'b0;
        end else begin
            state        <= state_next;
            wb_valid     <= 1'b0;
            wb_wr_enable <= 1'b0;
            misalign     <= take_trap;
            if (accept_alu) begin
                wb_valid     <= 1'b1;
                wb_rd        <= ex_rd;
                wb_result    <= ex_alu_result;
                wb_wr_enable <= ex_wr_enable;
            end
            if (accept_mem) begin
                dmem.dmem_req   <= 1'b1;
                dmem.dmem_we    <= ex_mem_write;
                dmem.dmem_addr  <= addr_aligned;
                dmem.dmem_be    <= be_calc;
                dmem.dmem_wdata <= wdata_rep;
                ld_load         <= ex_mem_read;
                ld_wr           <= ex_wr_enable;
                ld_rd           <= ex_rd;
                ld_f3           <= ex_funct3;
                ld_off          <= addr_aligned[OFF_W-1:0];
                killed          <= 1'b0;
            end
            if (drop_req) begin
                dmem.dmem_req <= 1'b0;
                dmem.dmem_we  <= 1'b0;
            end
            // a load killed at or after grant still has to drain its response
            if (flush && ((state == REQ && dmem.dmem_gnt) || state == WAIT)) begin
                killed <= 1'b1;
            end
            if (retire) begin
                wb_valid     <= 1'b1;
                wb_rd        <= ld_rd;
                wb_wr_enable <= ld_load & ld_wr;
                if (ld_load) begin
                    wb_result <= load_result;
                end
            end
        end
    end
endmodule

// File: tb/tb_stage_memory_lsu.sv
// Self-checking bench for stage_memory_lsu: directed scenarios plus randomized ops vs. an arithmetic model.
module tb_stage_memory_lsu;
    localparam int XLEN = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_read, ex_mem_write, ex_wr_enable, flush;
    logic [4:0]  ex_rd;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [2:0]  ex_funct3;
    logic        mem_stall, wb_valid, wb_wr_enable, misalign;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    stage_memory_lsu_if #(.XLEN(XLEN)) bus ();

    stage_memory_lsu #(.XLEN(XLEN), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_rd(ex_rd),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_wr_enable(ex_wr_enable), .flush(flush), .mem_stall(mem_stall), .dmem(bus),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_result(wb_result),
        .wb_wr_enable(wb_wr_enable), .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte-level arithmetic on a 32-bit little-endian word
    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic logic [31:0] m_addr(input logic [31:0] a, input logic [2:0] f3);
        longint av = longint'(a);
        return 32'(av - (av % size_of(f3)));
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
        longint off = longint'(a) % 4;
        return 4'(((longint'(1) << size_of(f3)) - 1) << off);
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f3);
        int     sz = size_of(f3);
        longint chunk = longint'(d) % (longint'(1) << (8 * sz));
        longint w = 0;
        for (int k = 0; k < 4 / sz; k++) w = w + (chunk << (8 * sz * k));
        return 32'(w);
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
        int     sz = size_of(f3);
        longint off = longint'(a) % 4;
        longint v = (longint'(rd) >> (8 * off)) % (longint'(1) << (8 * sz));
        if (f3 < 3'd4 && sz < 4 && v >= (longint'(1) << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
        return 32'(v);
    endfunction

    task automatic run_alu(input string tag, input logic [4:0] rd, input logic [31:0] res, input bit wren);
        ex_valid = 1; ex_mem_read = 0; ex_mem_write = 0; ex_rd = rd;
        ex_alu_result = res; ex_wr_enable = wren; ex_funct3 = 3'($urandom);
        @(posedge clk); #1;
        ex_valid = 0;
        chk({tag, ".wb_valid"}, wb_valid, 1);
        chk({tag, ".wb_rd"}, wb_rd, rd);
        chk({tag, ".wb_result"}, wb_result, res);
        chk({tag, ".wb_wr_enable"}, wb_wr_enable, wren);
        chk({tag, ".stall"}, mem_stall, 0);
        @(posedge clk); #1;
        chk({tag, ".pulse"}, wb_valid, 0);
    endtask

    task automatic run_mem(input string tag, input bit is_load, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] sdata, input logic [31:0] rdata,
                           input int gd, input int rdly, input logic [4:0] rd, input bit wren);
        logic [31:0] ea;
        int req_cycles, wait_cycles, stall_cycles, lat;
        bit granted;
        ea = m_addr(addr, f3);
        req_cycles = 0; wait_cycles = 0; stall_cycles = 0; lat = 0; granted = 0;
        ex_valid = 1; ex_mem_read = is_load; ex_mem_write = !is_load; ex_funct3 = f3;
        ex_alu_result = addr; ex_store_data = sdata; ex_rd = rd; ex_wr_enable = wren;
        @(posedge clk); #1;
        // unrelated ALU op held during the stall must be ignored
        ex_mem_read = 0; ex_mem_write = 0; ex_alu_result = $urandom; ex_rd = 5'($urandom);
        chk({tag, ".req"}, bus.dmem_req, 1);
        chk({tag, ".we"}, bus.dmem_we, !is_load);
        chk({tag, ".be"}, bus.dmem_be, m_be(ea, f3));
        if (!is_load) chk({tag, ".wdata"}, bus.dmem_wdata, m_wdata(sdata, f3));
        for (int c = 1; c <= 40; c++) begin
            if (wb_valid) begin
                lat = c;
                break;
            end
            if (mem_stall) stall_cycles++;
            bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = $urandom;
            if (bus.dmem_req) begin
                chk({tag, ".addr_hold"}, bus.dmem_addr, ea);
                if (req_cycles == gd) begin
                    bus.dmem_gnt = 1;
                    granted = 1;
                end else begin
                    bus.dmem_rvalid = 1'($urandom_range(0, 1));
                end
                req_cycles++;
            end else if (granted && is_load) begin
                if (wait_cycles == rdly) begin
                    bus.dmem_rvalid = 1;
                    bus.dmem_rdata = rdata;
                end
                wait_cycles++;
            end
            @(posedge clk); #1;
        end
        ex_valid = 0; bus.dmem_gnt = 0; bus.dmem_rvalid = 0;
        chk({tag, ".latency"}, lat, is_load ? 3 + gd + rdly : 2 + gd);
        chk({tag, ".stall_cycles"}, stall_cycles, is_load ? 2 + gd + rdly : 1 + gd);
        chk({tag, ".stall_end"}, mem_stall, 0);
        chk({tag, ".wb_rd"}, wb_rd, rd);
        chk({tag, ".wb_wr_enable"}, wb_wr_enable, is_load ? wren : 1'b0);
        if (is_load) chk({tag, ".wb_result"}, wb_result, m_load(rdata, ea, f3));
        @(posedge clk); #1;
        chk({tag, ".pulse"}, wb_valid, 0);
        chk({tag, ".req_idle"}, bus.dmem_req, 0);
    endtask

    initial begin
        logic [31:0] a;
        logic [2:0]  f;
        rst = 1; ex_valid = 0; ex_mem_read = 0; ex_mem_write = 0; ex_wr_enable = 0; flush = 0;
        ex_rd = 0; ex_alu_result = 0; ex_store_data = 0; ex_funct3 = 0;
        bus.dmem_gnt = 0; bus.dmem_rvalid = 0; bus.dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("reset.req", bus.dmem_req, 0);
        chk("reset.wb_valid", wb_valid, 0);
        chk("reset.stall", mem_stall, 0);
        chk("reset.misalign", misalign, 0);

        run_alu("alu", 5'd7, 32'h0000_1234, 1'b1);
        run_mem("lb", 1'b1, 3'b000, 32'h1003, 32'h0, 32'h80FF_FFFF, 0, 0, 5'd3, 1'b1);
        run_mem("sh", 1'b0, 3'b001, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 0, 5'd9, 1'b0);
        run_mem("lhu", 1'b1, 3'b101, 32'h1002, 32'h0, 32'h8001_2345, 1, 2, 5'd4, 1'b1);

        // flush while the load waits for rvalid
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h3000; ex_rd = 5'd6; ex_wr_enable = 1;
        @(posedge clk); #1;
        ex_valid = 0; bus.dmem_gnt = 1;
        @(posedge clk); #1;
        bus.dmem_gnt = 0; flush = 1;
        chk("flw.wait_stall", mem_stall, 1);
        chk("flw.wait_req", bus.dmem_req, 0);
        @(posedge clk); #1;
        flush = 0;
        chk("flw.no_wb1", wb_valid, 0);
        @(posedge clk); #1;
        bus.dmem_rvalid = 1; bus.dmem_rdata = 32'hDEAD_BEEF;
        chk("flw.still_stall", mem_stall, 1);
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        chk("flw.no_wb2", wb_valid, 0);
        chk("flw.stall_drop", mem_stall, 0);

        // flush in REQ before grant
        ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_funct3 = 3'b010;
        ex_alu_result = 32'h5000; ex_store_data = 32'h1111_2222;
        @(posedge clk); #1;
        ex_valid = 0; flush = 1;
        @(posedge clk); #1;
        flush = 0;
        chk("freq.req", bus.dmem_req, 0);
        chk("freq.stall", mem_stall, 0);
        chk("freq.wb", wb_valid, 0);
        run_alu("alu2", 5'd12, 32'hA5A5_0001, 1'b0);

`ifdef MEM_MISALIGN_TRAP_EN
        ex_valid = 1; ex_mem_read = 1; ex_mem_write = 0; ex_funct3 = 3'b010;
        ex_alu_result = 32'h1002; ex_rd = 5'd2; ex_wr_enable = 1;
        @(posedge clk); #1;
        ex_valid = 0;
        chk("mis.pulse", misalign, 1);
        chk("mis.req", bus.dmem_req, 0);
        chk("mis.wb", wb_valid, 0);
        chk("mis.stall", mem_stall, 0);
        @(posedge clk); #1;
        chk("mis.pulse_end", misalign, 0);
        chk("mis.req2", bus.dmem_req, 0);
`else
        run_mem("lw_mis", 1'b1, 3'b010, 32'h1002, 32'h0, 32'hCAFE_F00D, 0, 0, 5'd2, 1'b1);
        chk("mis.tied", misalign, 0);
`endif

        // reset during REQ, then a stray response
        ex_valid = 1; ex_mem_read = 0; ex_mem_write = 1; ex_funct3 = 3'b010;
        ex_alu_result = 32'h4000; ex_store_data = 32'h7777_8888;
        @(posedge clk); #1;
        ex_valid = 0;
        chk("rstreq.req", bus.dmem_req, 1);
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        chk("rstreq.req0", bus.dmem_req, 0);
        chk("rstreq.addr0", bus.dmem_addr, 0);
        chk("rstreq.be0", bus.dmem_be, 0);
        chk("rstreq.wdata0", bus.dmem_wdata, 0);
        chk("rstreq.wb_rd0", wb_rd, 0);
        chk("rstreq.wb_result0", wb_result, 0);
        chk("rstreq.stall0", mem_stall, 0);
        bus.dmem_rvalid = 1;
        @(posedge clk); #1;
        bus.dmem_rvalid = 0;
        chk("rstreq.stray_wb", wb_valid, 0);
        chk("rstreq.stray_req", bus.dmem_req, 0);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            a = 32'h0000_8000 + 32'($urandom_range(0, 255));
`ifdef MEM_MISALIGN_TRAP_EN
            a = m_addr(a, f);
`endif
            case ($urandom_range(0, 2))
                0: run_alu($sformatf("rnd%0d.alu", i), 5'($urandom), $urandom, 1'($urandom));
                1: run_mem($sformatf("rnd%0d.ld", i), 1'b1, f, a, 32'h0, $urandom,
                           $urandom_range(0, 3), $urandom_range(0, 3), 5'($urandom), 1'($urandom));
                default: run_mem($sformatf("rnd%0d.st", i), 1'b0, f, a, $urandom, 32'h0,
                                 $urandom_range(0, 3), 0, 5'($urandom), 1'($urandom));
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
